// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-port arbiter and strobe sequencer for the 32x8 data memory (option: MEM_ARB_RR_EN)
module mem_access_arbiter #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_done,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_done,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] mad,
   output logic          mrd,
   output logic          mwr,
   inout  wire  [DW-1:0] mdat
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          pick_b;
   logic          win_b;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic          mrd_q;
   logic          mwr_q;
   logic          drive_q;

`ifdef MEM_ARB_RR_EN
   logic          last_b;

   // Round-robin choice: a tie goes to the port that did not win last time.
   always_comb begin
      pick_b = 1'b0;
      if (a_req && b_req) begin
         pick_b = ~last_b;
      end else begin
         pick_b = b_req;
      end
   end

   // Remember the last winner; reset value points at B so A takes the first tie.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_b <= 1'b1;
      end else if (state == IDLE && (a_req || b_req)) begin
         last_b <= pick_b;
      end
   end
`else
   // Fixed priority choice: A wins every tie, B only when A is idle.
   always_comb begin
      pick_b = 1'b0;
      pick_b = b_req && !a_req;
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: a fixed three-cycle walk once any request is seen in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (a_req || b_req) state_nx = ACCESS;
         ACCESS:   state_nx = COMPLETE;
         COMPLETE: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Registered outputs and transaction latches; each edge sets up the next cycle's strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         win_b   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         mad     <= '0;
         mrd_q   <= 1'b0;
         mwr_q   <= 1'b0;
         drive_q <= 1'b0;
         a_gnt   <= 1'b0;
         b_gnt   <= 1'b0;
         a_done  <= 1'b0;
         b_done  <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  win_b   <= pick_b;
                  we_q    <= pick_b ? b_we : a_we;
                  wdata_q <= pick_b ? b_wdata : a_wdata;
                  mad     <= pick_b ? b_addr : a_addr;
                  mwr_q   <= pick_b ? b_we : a_we;
                  mrd_q   <= pick_b ? ~b_we : ~a_we;
                  drive_q <= pick_b ? b_we : a_we;
                  a_gnt   <= ~pick_b;
                  b_gnt   <= pick_b;
               end
            end
            ACCESS: begin
               a_gnt   <= 1'b0;
               b_gnt   <= 1'b0;
               mrd_q   <= 1'b0;
               mwr_q   <= 1'b0;
               drive_q <= 1'b0;
               a_done  <= ~win_b;
               b_done  <= win_b;
               if (!we_q) begin
                  if (win_b) begin
                     b_rdata <= mdat;
                  end else begin
                     a_rdata <= mdat;
                  end
               end
            end
            COMPLETE: begin
               a_done <= 1'b0;
               b_done <= 1'b0;
            end
            default: begin
               a_gnt  <= 1'b0;
               b_gnt  <= 1'b0;
               a_done <= 1'b0;
               b_done <= 1'b0;
            end
         endcase
      end
   end

   // The write strobe and bus drive are qualified by rst so an abort in ACCESS
   // never lets the memory capture the write on the reset edge.
   assign mrd  = mrd_q;
   assign mwr  = mwr_q & rst;
   assign mdat = (drive_q && rst) ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter with a behavioural 32x8 memory
module tb_mem_access_arbiter;

   logic       clk;
   logic       rst;
   logic       a_req, a_we, b_req, b_we;
   logic [4:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_gnt, a_done, b_gnt, b_done;
   logic [7:0] a_rdata, b_rdata;
   logic [4:0] mad;
   logic       mrd, mwr;
   wire  [7:0] mdat;

   logic [7:0] mem [0:31];

   typedef struct {
      bit         we;
      logic [7:0] rd;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   bit   done_log[$];

   int         checks = 0;
   int         errors = 0;
   int         a_act = 0;
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;

   mem_access_arbiter #(.AW(5), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
      .mad(mad), .mrd(mrd), .mwr(mwr), .mdat(mdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: asynchronous read onto the bus, synchronous write.
   assign mdat = mrd ? mem[mad] : 8'hzz;
   always @(posedge clk) begin
      if (mwr) mem[mad] <= mdat;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops the expected completion for whichever port signals done,
   // and checks the bus invariants every cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         last_a = 8'h00;
         last_b = 8'h00;
      end
      if (a_gnt || a_done) a_act++;
      if (a_done) begin
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_done_unexpected actual=1 required=0");
         end else begin
            e = exp_a.pop_front();
            if (!e.we) last_a = e.rd;
            check("a_rdata", a_rdata, last_a);
            done_log.push_back(1'b0);
         end
      end
      if (b_done) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_done_unexpected actual=1 required=0");
         end else begin
            e = exp_b.pop_front();
            if (!e.we) last_b = e.rd;
            check("b_rdata", b_rdata, last_b);
            done_log.push_back(1'b1);
         end
      end
      check("strobe_overlap", mrd && mwr, 0);
      check("gnt_overlap", a_gnt && b_gnt, 0);
      check("done_overlap", a_done && b_done, 0);
      if (!mrd && !mwr) check("mdat_float", mdat === 8'hzz, 1);
   end

   // Issue one request on a port and hold it until granted (bounded wait).
   task automatic drive(input bit port, input bit we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd);
      exp_t e;
      bit   got;
      e.we = we;
      e.rd = rd;
      got  = 1'b0;
      if (port) begin
         exp_b.push_back(e);
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
      end else begin
         exp_a.push_back(e);
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((port && b_gnt) || (!port && a_gnt)) begin
            got = 1'b1;
            break;
         end
      end
      check(port ? "b_gnt_timeout" : "a_gnt_timeout", got, 1);
      if (port) b_req = 1'b0;
      else      a_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int         snap;
      int         gcnt, dcnt;
      int         gpos[$];
      logic [2:0] order;

      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      rst = 1'b0;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_a_gnt", a_gnt, 0);
      check("rst_b_gnt", b_gnt, 0);
      check("rst_a_done", a_done, 0);
      check("rst_b_done", b_done, 0);
      check("rst_mrd", mrd, 0);
      check("rst_mwr", mwr, 0);
      check("rst_mad", mad, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_mdat", mdat === 8'hzz, 1);
      rst = 1'b1;
      @(negedge clk);

      // 1: port A write 5<=A5 with exact cycle timing, then read it back.
      exp_a.push_back('{we: 1'b1, rd: 8'h00});
      a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'hA5;
      @(posedge clk); #1;
      a_req = 0;
      check("t1_gnt_c1", a_gnt, 1);
      check("t1_mwr_c1", mwr, 1);
      check("t1_mdat_c1", mdat, 8'hA5);
      check("t1_mad_c1", mad, 5);
      @(posedge clk); #1;
      check("t1_done_c2", a_done, 1);
      check("t1_gnt_c2", a_gnt, 0);
      check("t1_mwr_c2", mwr, 0);
      @(negedge clk);
      drive(0, 0, 5'd5, 8'h00, 8'hA5);
      repeat (2) @(negedge clk);

      // 2: port B only, write 31<=3C then read it back; A stays silent.
      snap = a_act;
      drive(1, 1, 5'd31, 8'h3C, 8'h00);
      drive(1, 0, 5'd31, 8'h00, 8'h3C);
      repeat (2) @(negedge clk);
      check("t2_a_quiet", a_act, snap);

      // 3: tie with A holding two requests and B one.
      done_log.delete();
      fork
         begin
            drive(0, 0, 5'd31, 8'h00, 8'h3C);
            drive(0, 0, 5'd5, 8'h00, 8'hA5);
         end
         drive(1, 0, 5'd5, 8'h00, 8'hA5);
      join
      repeat (3) @(negedge clk);
`ifdef MEM_ARB_RR_EN
      order = 3'b010;
`else
      order = 3'b001;
`endif
      check("t3_count", done_log.size(), 3);
      if (done_log.size() == 3)
         check("t3_order", {done_log[0], done_log[1], done_log[2]}, order);

      // 4: abort a write to addr 7 during ACCESS; old value 11 must survive.
      drive(0, 1, 5'd7, 8'h11, 8'h00);
      repeat (2) @(negedge clk);
      a_req = 1; a_we = 1; a_addr = 5'd7; a_wdata = 8'h22;
      @(posedge clk); #1;
      check("t4_gnt", a_gnt, 1);
      rst = 1'b0;
      a_req = 0;
      #1;
      check("t4_mwr_drop", mwr, 0);
      check("t4_mdat_drop", mdat === 8'hzz, 1);
      @(posedge clk); #1;
      check("t4_a_gnt", a_gnt, 0);
      check("t4_a_done", a_done, 0);
      check("t4_mwr", mwr, 0);
      check("t4_mrd", mrd, 0);
      check("t4_mad", mad, 0);
      check("t4_a_rdata", a_rdata, 0);
      check("t4_mdat", mdat === 8'hzz, 1);
      rst = 1'b1;
      @(negedge clk);
      drive(0, 0, 5'd7, 8'h00, 8'h11);
      repeat (2) @(negedge clk);

      // 5: a_req held for 9 cycles reading addr 5.
      for (int i = 0; i < 3; i++) exp_a.push_back('{we: 1'b0, rd: 8'hA5});
      gcnt = 0;
      dcnt = 0;
      a_req = 1; a_we = 0; a_addr = 5'd5;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (a_gnt) begin
            gcnt++;
            gpos.push_back(i);
         end
         if (a_done) dcnt++;
      end
      a_req = 0;
      check("t5_gnt_count", gcnt, 3);
      check("t5_done_count", dcnt, 3);
      if (gpos.size() == 3) begin
         check("t5_gnt0", gpos[0], 1);
         check("t5_gnt1", gpos[1], 4);
         check("t5_gnt2", gpos[2], 7);
      end
      repeat (2) @(negedge clk);

      // 6: B write FF to 12, then A read of 12 back-to-back; mad holds between.
      drive(1, 1, 5'd12, 8'hFF, 8'h00);
      fork
         drive(0, 0, 5'd12, 8'h00, 8'hFF);
         begin
            @(negedge clk);
            check("t6_mad_complete", mad, 12);
            @(negedge clk);
            check("t6_mad_idle", mad, 12);
         end
      join
      repeat (3) @(negedge clk);
      check("t6_a_rdata", a_rdata, 8'hFF);

      check("exp_a_drained", exp_a.size(), 0);
      check("exp_b_drained", exp_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
